// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_unit_fa_bit.sv
// One-bit full adder used once per serial step.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial adder/subtractor: processes one bit per cycle LSB-first,
// publishing result, carry-out and overflow together with a done pulse.
module serial_add_unit
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic             carry_msb;
  logic [CW-1:0]    cnt;
  logic             sum_bit;
  logic             carry_next;

  fa_bit u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .s   (sum_bit),
    .co  (carry_next)
  );

  // Control and datapath; result/flags only update on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      carry_msb <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= (op == OP_SUB) ? ~b : b;
            carry <= op;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= {sum_bit, acc[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= carry_next;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 2)) begin
            carry_msb <= carry_next;
          end
          if (cnt == CW'(WIDTH - 1)) begin
            result <= {sum_bit, acc[WIDTH-1:1]};
            cout   <= carry_next;
            ovf    <= carry_msb ^ carry_next;
            cnt    <= '0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_unit.sv
// Self-checking bench for serial_add_unit against an integer-arithmetic model.
module tb_serial_add_unit;
  import serial_add_pkg::*;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] held_res;
  logic         held_cout;
  logic         held_ovf;

  serial_add_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned sum for result/carry, signed sum range for overflow.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                                output logic [W-1:0] r, output logic c, output logic v);
    int ux;
    int uy;
    int sum;
    int sx;
    int sy;
    int tr;
    ux  = int'(x);
    uy  = int'(y);
    sum = o ? (ux + ((2 ** W) - 1 - uy) + 1) : (ux + uy);
    r   = W'(sum % (2 ** W));
    c   = (sum >= (2 ** W));
    sx  = (ux >= (2 ** (W - 1))) ? ux - (2 ** W) : ux;
    sy  = (uy >= (2 ** (W - 1))) ? uy - (2 ** W) : uy;
    tr  = o ? (sx - sy) : (sx + sy);
    v   = (tr < -(2 ** (W - 1))) || (tr > (2 ** (W - 1)) - 1);
  endfunction

  task automatic idle_hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_result", 32'(result), 32'(held_res));
      check("idle_cout", 32'(cout), 32'(held_cout));
      check("idle_ovf", 32'(ovf), 32'(held_ovf));
    end
  endtask

  // One operation with scrambled inputs and stray start pulses while busy.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                        input logic [W-1:0] er, input logic ec, input logic ev);
    @(negedge clk);
    start = 1'b1; a = x; b = y; op = o;
    @(posedge clk); #1;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_done", 32'(done), 32'd0);
    for (int k = 1; k <= int'(W) + 1; k++) begin
      @(negedge clk);
      a     = W'($urandom);
      b     = W'($urandom);
      op    = 1'($urandom);
      start = 1'($urandom);
      @(posedge clk); #1;
      if (k < int'(W)) begin
        check("shift_done", 32'(done), 32'd0);
        check("shift_busy", 32'(busy), 32'd1);
        check("shift_result_held", 32'(result), 32'(held_res));
      end else if (k == int'(W)) begin
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        check("result", 32'(result), 32'(er));
        check("cout", 32'(cout), 32'(ec));
        check("ovf", 32'(ovf), 32'(ev));
      end else begin
        check("post_done", 32'(done), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_result", 32'(result), 32'(er));
      end
    end
    @(negedge clk);
    start     = 1'b0;
    held_res  = er;
    held_cout = ec;
    held_ovf  = ev;
  endtask

  initial begin
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic         ro;
    logic [W-1:0] mr;
    logic         mc;
    logic         mv;
    int           done_idx[$];
    int           low_cnt;
    int           sep;

    rst = 1'b1; start = 1'b0; op = OP_ADD; a = '0; b = '0;
    held_res = '0; held_cout = 1'b0; held_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_hold(2);

    // Directed cases with hand-computed expectations.
    run_op(4'b0011, 4'b0101, OP_ADD, 4'b1000, 1'b0, 1'b1);
    idle_hold(1);
    run_op(4'b0101, 4'b0011, OP_SUB, 4'b0010, 1'b1, 1'b0);
    idle_hold(1);
    run_op(4'b0011, 4'b0101, OP_SUB, 4'b1110, 1'b0, 1'b0);
    idle_hold(1);
    run_op(4'b1111, 4'b0001, OP_ADD, 4'b0000, 1'b1, 1'b0);
    idle_hold(1);
    run_op(4'b0110, 4'b0001, OP_ADD, 4'b0111, 1'b0, 1'b0);
    idle_hold(2);

    // Start held high: back-to-back operations.
    @(negedge clk);
    a = 4'b0001; b = 4'b0001; op = OP_ADD; start = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        done_idx.push_back(i);
        check("held_result", 32'(result), 32'd2);
      end
      if (!busy && done_idx.size() == 1) low_cnt++;
    end
    @(negedge clk);
    start = 1'b0;
    check("held_pulses", 32'(done_idx.size()), 32'd2);
    sep = (done_idx.size() == 2) ? done_idx[1] - done_idx[0] : -1;
    check("held_separation", 32'(sep), 32'd6);
    check("held_busy_low", 32'(low_cnt), 32'd1);
    held_res = 4'b0010; held_cout = 1'b0; held_ovf = 1'b0;
    idle_hold(1);

    // Reset during the third shift cycle abandons the operation.
    @(negedge clk);
    a = 4'b0101; b = 4'b0011; op = OP_SUB; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    held_res = '0; held_cout = 1'b0; held_ovf = 1'b0;
    idle_hold(8);

    // Randomized operations against the model.
    for (int n = 0; n < 24; n++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      ro = 1'($urandom);
      model(rx, ry, ro, mr, mc, mv);
      run_op(rx, ry, ro, mr, mc, mv);
      idle_hold(int'($urandom_range(1, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
